// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt controller blocks: default level count,
// level-index width helper and EOI command kinds.
package pic_pkg;

    localparam int PIC_N_IRQ = 8;

    typedef enum logic {
        EOI_NONSPEC = 1'b0,
        EOI_SPEC    = 1'b1
    } eoi_kind;

    // Width of a level index; never below one bit so two-level builds still have a port.
    function automatic int lvl_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pic_rot_prio_enc.sv
// Rotating priority encoder: finds the first set bit of vec, searching upward
// (with wrap) from the level just above lowest_prio.
module pic_rot_prio_enc
    import pic_pkg::*;
#(
    parameter  int N_IRQ = PIC_N_IRQ,
    localparam int LVL_W = lvl_w(N_IRQ)
) (
    input  logic [N_IRQ-1:0] vec,
    input  logic [LVL_W-1:0] lowest_prio,
    output logic             valid,
    output logic [LVL_W-1:0] level
);

    always_comb begin
        int idx;
        valid = 1'b0;
        level = '0;
        idx   = 0;
        for (int i = 0; i < N_IRQ; i++) begin
            // lowest_prio never exceeds N_IRQ-1, so one subtraction is enough to wrap.
            idx = int'(lowest_prio) + 1 + i;
            if (idx >= N_IRQ) begin
                idx = idx - N_IRQ;
            end
            if (!valid && vec[idx]) begin
                valid = 1'b1;
                level = LVL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/pic_isr_rotating.sv
// In-service register with EOI/AEOI handling and rotating priority base.
// Commands are single-cycle pulses; all effects are computed from pre-edge state.
module pic_isr_rotating
    import pic_pkg::*;
#(
    parameter  int N_IRQ = PIC_N_IRQ,
    localparam int LVL_W = lvl_w(N_IRQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ack_set_i,
    input  logic [LVL_W-1:0] ack_level_i,
    input  logic             aeoi_en_i,
    input  logic             eoi_i,
    input  logic             eoi_specific_i,
    input  logic [LVL_W-1:0] eoi_level_i,
    input  logic             rotate_on_eoi_i,
    input  logic             prio_set_i,
    input  logic [LVL_W-1:0] prio_level_i,
    output logic [N_IRQ-1:0] isr_o,
    output logic             top_valid_o,
    output logic [LVL_W-1:0] top_level_o,
    output logic [LVL_W-1:0] lowest_prio_o
);

    logic [N_IRQ-1:0] isr_q, isr_d;
    logic [LVL_W-1:0] lowest_q, lowest_d;
    logic             eoi_hit;
    logic [LVL_W-1:0] eoi_lvl;
    logic             aeoi_hit;
    eoi_kind          kind;

    // Out-of-range levels only exist for non-power-of-two N_IRQ; such commands are dropped.
    function automatic logic lvl_ok(input logic [LVL_W-1:0] l);
        return int'(l) < N_IRQ;
    endfunction

    assign kind = eoi_kind'(eoi_specific_i);

    pic_rot_prio_enc #(.N_IRQ(N_IRQ)) u_enc (
        .vec         (isr_q),
        .lowest_prio (lowest_q),
        .valid       (top_valid_o),
        .level       (top_level_o)
    );

    always_comb begin
        isr_d    = isr_q;
        lowest_d = lowest_q;
        eoi_hit  = 1'b0;
        eoi_lvl  = '0;
        aeoi_hit = 1'b0;

        if (eoi_i) begin
            if (kind == EOI_SPEC) begin
                if (lvl_ok(eoi_level_i)) begin
                    eoi_hit = 1'b1;
                    eoi_lvl = eoi_level_i;
                end
            end else if (top_valid_o) begin
                eoi_hit = 1'b1;
                eoi_lvl = top_level_o;
            end
        end
        if (eoi_hit) begin
            isr_d[eoi_lvl] = 1'b0;
        end

        // Ack is applied after the clear, so an EOI and re-ack of one level leaves it set.
        if (ack_set_i && lvl_ok(ack_level_i)) begin
            if (aeoi_en_i) begin
                aeoi_hit = 1'b1;
            end else begin
                isr_d[ack_level_i] = 1'b1;
            end
        end

        if (prio_set_i && lvl_ok(prio_level_i)) begin
            lowest_d = prio_level_i;
        end else if (rotate_on_eoi_i && eoi_hit) begin
            lowest_d = eoi_lvl;
        end else if (rotate_on_eoi_i && aeoi_hit) begin
            lowest_d = ack_level_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isr_q    <= '0;
            lowest_q <= LVL_W'(N_IRQ - 1);
        end else begin
            isr_q    <= isr_d;
            lowest_q <= lowest_d;
        end
    end

    assign isr_o         = isr_q;
    assign lowest_prio_o = lowest_q;

endmodule

// File: tb/tb_pic_isr_rotating.sv
// Directed and randomized checks of the in-service register against a
// behavioural model; a second six-level instance covers out-of-range levels.
module tb_pic_isr_rotating;

    logic clk;
    logic rst_n;

    logic       ack_set, aeoi_en, eoi, eoi_specific, rotate, prio_set;
    logic [2:0] ack_level, eoi_level, prio_level;
    logic [7:0] isr;
    logic       top_valid;
    logic [2:0] top_level, lowest_prio;

    logic       s_ack, s_aeoi, s_eoi, s_spec, s_rot, s_ps;
    logic [2:0] s_al, s_el, s_pl;
    logic [5:0] isr6;
    logic       top_valid6;
    logic [2:0] top_level6, lowest6;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] m_isr;
    int         m_low;

    pic_isr_rotating #(.N_IRQ(8)) dut (
        .clk (clk), .rst_n (rst_n),
        .ack_set_i (ack_set), .ack_level_i (ack_level), .aeoi_en_i (aeoi_en),
        .eoi_i (eoi), .eoi_specific_i (eoi_specific), .eoi_level_i (eoi_level),
        .rotate_on_eoi_i (rotate), .prio_set_i (prio_set), .prio_level_i (prio_level),
        .isr_o (isr), .top_valid_o (top_valid), .top_level_o (top_level),
        .lowest_prio_o (lowest_prio)
    );

    pic_isr_rotating #(.N_IRQ(6)) dut6 (
        .clk (clk), .rst_n (rst_n),
        .ack_set_i (s_ack), .ack_level_i (s_al), .aeoi_en_i (s_aeoi),
        .eoi_i (s_eoi), .eoi_specific_i (s_spec), .eoi_level_i (s_el),
        .rotate_on_eoi_i (s_rot), .prio_set_i (s_ps), .prio_level_i (s_pl),
        .isr_o (isr6), .top_valid_o (top_valid6), .top_level_o (top_level6),
        .lowest_prio_o (lowest6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Highest-priority set level: scan upward from the level after the lowest one.
    function automatic int m_top(input logic [7:0] v, input int low);
        for (int k = 1; k <= 8; k++) begin
            if (v[(low + k) % 8]) return (low + k) % 8;
        end
        return 0;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".isr"}, 32'(isr), 32'(m_isr));
        chk({tag, ".low"}, 32'(lowest_prio), m_low);
        chk({tag, ".valid"}, 32'(top_valid), 32'(m_isr != 8'h00));
        chk({tag, ".top"}, 32'(top_level), m_top(m_isr, m_low));
    endtask

    // One clock of commands on the 8-level instance, mirrored into the model.
    task automatic cmd(input string tag, input bit a, input int al, input bit ae,
                       input bit e, input bit es, input int el, input bit rot,
                       input bit ps, input int pl);
        int cleared;
        logic [7:0] nxt;
        ack_set = a; ack_level = 3'(al); aeoi_en = ae;
        eoi = e; eoi_specific = es; eoi_level = 3'(el);
        rotate = rot; prio_set = ps; prio_level = 3'(pl);

        cleared = -1;
        nxt = m_isr;
        if (e) begin
            if (es) cleared = el;
            else if (m_isr != 8'h00) cleared = m_top(m_isr, m_low);
        end
        if (cleared >= 0) nxt[cleared] = 1'b0;
        if (a && !ae) nxt[al] = 1'b1;
        if (ps) m_low = pl;
        else if (rot && cleared >= 0) m_low = cleared;
        else if (rot && a && ae) m_low = al;
        m_isr = nxt;

        @(posedge clk);
        #1;
        ack_set = 1'b0; eoi = 1'b0; prio_set = 1'b0;
        check_model(tag);
    endtask

    task automatic step6();
        @(posedge clk);
        #1;
        s_ack = 1'b0; s_eoi = 1'b0; s_ps = 1'b0;
    endtask

    initial begin
        ack_set = 0; ack_level = 0; aeoi_en = 0; eoi = 0; eoi_specific = 0;
        eoi_level = 0; rotate = 0; prio_set = 0; prio_level = 0;
        s_ack = 0; s_al = 0; s_aeoi = 0; s_eoi = 0; s_spec = 0; s_el = 0;
        s_rot = 0; s_ps = 0; s_pl = 0;
        m_isr = 8'h00;
        m_low = 7;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        chk("reset.isr", 32'(isr), 32'h0);
        chk("reset.low", 32'(lowest_prio), 32'd7);
        chk("reset.valid", 32'(top_valid), 32'd0);
        chk("reset.top", 32'(top_level), 32'd0);
        chk("reset.low6", 32'(lowest6), 32'd5);
        #19 rst_n = 1'b1;

        // Fully nested: ack 3 then 1.
        cmd("ack3", 1, 3, 0, 0, 0, 0, 0, 0, 0);
        cmd("ack1", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("nest.isr", 32'(isr), 32'h0A);
        chk("nest.top", 32'(top_level), 32'd1);
        chk("nest.valid", 32'(top_valid), 32'd1);
        chk("nest.low", 32'(lowest_prio), 32'd7);

        cmd("eoi_a", 0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("eoi_a.isr", 32'(isr), 32'h08);
        chk("eoi_a.top", 32'(top_level), 32'd3);
        cmd("eoi_b", 0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("eoi_b.isr", 32'(isr), 32'h00);
        chk("eoi_b.valid", 32'(top_valid), 32'd0);
        cmd("eoi_empty", 0, 0, 0, 1, 0, 0, 1, 0, 0);
        chk("eoi_empty.low", 32'(lowest_prio), 32'd7);

        // Rotating non-specific EOI.
        cmd("ack2", 1, 2, 0, 0, 0, 0, 1, 0, 0);
        cmd("ack5", 1, 5, 0, 0, 0, 0, 1, 0, 0);
        cmd("rot_eoi", 0, 0, 0, 1, 0, 0, 1, 0, 0);
        chk("rot_eoi.isr", 32'(isr), 32'h20);
        chk("rot_eoi.low", 32'(lowest_prio), 32'd2);
        chk("rot_eoi.top", 32'(top_level), 32'd5);
        cmd("ack0", 1, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("ack0.top", 32'(top_level), 32'd5);

        // Back to isr=0x02, then same-cycle ack and EOI.
        cmd("seoi5", 0, 0, 0, 1, 1, 5, 0, 0, 0);
        cmd("seoi0", 0, 0, 0, 1, 1, 0, 0, 0, 0);
        cmd("ack1b", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("pre.isr", 32'(isr), 32'h02);
        cmd("ack_eoi", 1, 4, 0, 1, 0, 0, 0, 0, 0);
        chk("ack_eoi.isr", 32'(isr), 32'h10);
        cmd("ps_eoi", 0, 0, 0, 1, 0, 0, 1, 1, 6);
        chk("ps_eoi.low", 32'(lowest_prio), 32'd6);

        // Automatic EOI with rotation.
        cmd("aeoi5", 1, 5, 1, 0, 0, 0, 1, 0, 0);
        chk("aeoi5.isr", 32'(isr), 32'h00);
        chk("aeoi5.low", 32'(lowest_prio), 32'd5);
        cmd("seoi7", 0, 0, 1, 1, 1, 7, 1, 0, 0);
        chk("seoi7.isr", 32'(isr), 32'h00);
        chk("seoi7.low", 32'(lowest_prio), 32'd7);

        // EOI rotation beats AEOI rotation in the same cycle.
        cmd("ack3b", 1, 3, 0, 0, 0, 0, 0, 0, 0);
        cmd("eoi_aeoi", 1, 6, 1, 1, 0, 0, 1, 0, 0);
        chk("eoi_aeoi.low", 32'(lowest_prio), 32'd3);

        for (int i = 0; i < 300; i++) begin
            cmd("rand", $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
                $urandom_range(0, 7));
        end
        aeoi_en = 1'b0;
        rotate = 1'b0;

        // Six-level instance: out-of-range levels are ignored.
        s_ack = 1; s_al = 3'd6;
        step6();
        chk("n6.ack6", 32'(isr6), 32'h0);
        s_aeoi = 1; s_rot = 1; s_ack = 1; s_al = 3'd7;
        step6();
        chk("n6.aeoi7", 32'(lowest6), 32'd5);
        s_aeoi = 0;
        s_eoi = 1; s_spec = 1; s_el = 3'd6;
        step6();
        chk("n6.seoi6", 32'(lowest6), 32'd5);
        s_ps = 1; s_pl = 3'd7;
        step6();
        chk("n6.ps7", 32'(lowest6), 32'd5);
        s_rot = 0;
        s_ack = 1; s_al = 3'd0;
        step6();
        s_ack = 1; s_al = 3'd5;
        step6();
        chk("n6.isr", 32'(isr6), 32'h21);
        chk("n6.top", 32'(top_level6), 32'd0);
        chk("n6.valid", 32'(top_valid6), 32'd1);

        // Asynchronous reset between clock edges.
        #2 rst_n = 1'b0;
        #1;
        chk("arst.isr6", 32'(isr6), 32'h0);
        chk("arst.low6", 32'(lowest6), 32'd5);
        chk("arst.valid6", 32'(top_valid6), 32'd0);
        chk("arst.low8", 32'(lowest_prio), 32'd7);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pic_isr_rotating.md
Name: pic_isr_rotating

Overview:
Clocked, parametrised in-service register (ISR) for the PIC. Sets a level's bit on interrupt acknowledge and clears bits on EOI commands (non-specific, specific, automatic). Supports fully-nested and rotating priority. Sits between the priority resolver and control logic: reports the in-service vector, the highest-priority in-service level, and the current rotation base the resolver compares against.

Parameters:
N_IRQ, 8, number of interrupt levels (2..32).
LVL_W, $clog2(N_IRQ), level-index width. Derived; never overridden.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
ack_set_i  in  1  one-cycle pulse: acknowledge of level ack_level_i.
ack_level_i  in  LVL_W  level being acknowledged.
aeoi_en_i  in  1  automatic-EOI mode.
eoi_i  in  1  one-cycle pulse: EOI command.
eoi_specific_i  in  1  1 = specific EOI of eoi_level_i; 0 = non-specific.
eoi_level_i  in  LVL_W  level for specific EOI.
rotate_on_eoi_i  in  1  rotate priority on EOI/AEOI.
prio_set_i  in  1  one-cycle pulse: set-priority command.
prio_level_i  in  LVL_W  new lowest-priority level.
isr_o  out  N_IRQ  in-service vector (registered).
top_valid_o  out  1  at least one bit of isr_o set.
top_level_o  out  LVL_W  highest-priority in-service level.
lowest_prio_o  out  LVL_W  current lowest-priority level (registered).

Behaviour:
- Reset (async assert, sync-style deassert at the next clk edge): isr_o=0, lowest_prio_o=N_IRQ-1 (IR0 highest), top_valid_o=0, top_level_o=0.
- Priority order: highest = (lowest_prio_o+1) mod N_IRQ, then ascending with wrap; lowest_prio_o itself is lowest.
- top_valid_o/top_level_o are combinational from registered isr_o and lowest_prio_o. No extra latency: they are valid in the cycle after the edge that updates state. When top_valid_o=0, top_level_o=0.
- Per-edge update order, evaluated on pre-edge state: (1) EOI clear, (2) ack set, (3) rotation update.
- Non-specific EOI: clear the top_level_o bit. If isr_o==0: no-op, no rotation.
- Specific EOI: clear bit eoi_level_i. Clearing a bit that is already 0 is legal and has no effect on isr_o.
- Ack, aeoi_en_i=0: set bit ack_level_i. Re-ack of a set bit: no change.
- Ack, aeoi_en_i=1: isr_o unchanged; the level is treated as serviced and ended in the same cycle.
- Rotation, in precedence order:
  - prio_set_i=1 → lowest_prio_o=prio_level_i. This wins over all other rotation sources.
  - Else rotate_on_eoi_i=1 with an effective EOI → lowest_prio_o = cleared level (non-specific: pre-edge top_level_o; specific: eoi_level_i, even if its bit was 0).
  - Else rotate_on_eoi_i=1 with an AEOI ack → lowest_prio_o=ack_level_i.
- Same-cycle EOI and AEOI ack with rotation enabled: the EOI rotation wins.
- Level inputs ≥ N_IRQ (non-power-of-2 N_IRQ): the command is ignored entirely, including rotation.
- Reset asserted mid-operation: state returns to reset values immediately. Commands pulsed during reset are lost.
- Commands are single-cycle pulses. Held-high inputs re-apply each cycle; this is idempotent for ack, cumulative for non-specific EOI.

Decomposition:
- Shared package pic_pkg: N_IRQ default, lvl_w() helper function, eoi_kind enum (EOI_NONSPEC, EOI_SPEC).
- One sub-module, pic_rot_prio_enc: parametrised rotating priority encoder (vector, lowest_prio → valid, level). The priority resolver reuses it.
- Top level holds the ISR register, rotation register and command sequencing.

Test Plan:
- Reset, then ack 3, then ack 1 → isr_o=0x0A, top_level_o=1, top_valid_o=1, lowest_prio_o=7.
- isr_o=0x0A, non-specific EOI → isr_o=0x08, top_level_o=3. Second non-specific EOI → isr_o=0, top_valid_o=0. Third EOI → no change.
- rotate_on_eoi_i=1, isr_o=0x24, non-specific EOI → isr_o=0x20, lowest_prio_o=2, top_level_o=5. Ack 0 → top_level_o=5 (5 outranks 0 under base 2).
- isr_o=0x02, same-cycle ack 4 and non-specific EOI → isr_o=0x10. Same-cycle prio_set 6 and rotating EOI → lowest_prio_o=6.
- aeoi_en_i=1, rotate_on_eoi_i=1, ack 5 → isr_o unchanged (0x00), lowest_prio_o=5. Specific EOI of 7 with isr_o=0 → isr_o=0, lowest_prio_o=7.
- N_IRQ=6: ack level 6 → ignored. With isr_o=0x21, rst_n asserted mid-cycle → isr_o=0 and lowest_prio_o=5 without waiting for a clk edge.
